fetch_aligner: RTL and testbench

- Fetch-side parcel steering stage for the RV32IC pipeline, sitting between instruction memory and the IF/ID register.
- Takes a stream of word-aligned 32-bit fetch words and splits them into 16-bit parcels.
- Reassembles the parcels into a registered, in-order stream of one instruction per cycle: either one 16-bit compressed instruction or one 32-bit instruction, which may straddle two words.
- Emits each instruction with its halfword-aligned PC and an RVC flag. Decompression happens downstream and is not part of this block.

---
 rtl/fetch_aligner_pkg.sv | 15 +
 rtl/fetch_aligner_if.sv | 27 ++
 rtl/fetch_aligner.sv | 124 ++++++++++++
 tb/tb_fetch_aligner.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_aligner_pkg.sv
// Shared definitions for the fetch aligner: FSM encoding and RVC parcel classification.
// The downstream decompressor imports is_rvc() from here as well.
package fetch_aligner_pkg;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HALF  = 1'b1;

  localparam logic [1:0] RVC_QUAD_FULL = 2'b11;

  // A 16-bit parcel is a complete compressed instruction unless its quadrant is 2'b11.
  function automatic logic is_rvc(input logic [15:0] parcel);
    return parcel[1:0] != RVC_QUAD_FULL;
  endfunction

endpackage

// File: rtl/fetch_aligner_if.sv
// Fetch-word input, redirect and instruction-output handshakes of the fetch aligner.
// master = fetch unit / decode side environment, slave = the aligner itself.
interface fetch_aligner_if #(
  parameter int PC_W = 32
);
  logic            flush;
  logic [PC_W-1:0] redirect_pc;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_word;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic            out_rvc;

  modport master (
    output flush, redirect_pc, in_valid, in_word, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_rvc
  );

  modport slave (
    input  flush, redirect_pc, in_valid, in_word, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_rvc
  );
endinterface

// File: rtl/fetch_aligner.sv
// Splits word-aligned fetch words into parcels and emits one registered instruction per cycle.
// Compressed (RVC) support is enabled by defining RVC_EN; otherwise every word is one instruction.
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_aligner_if.slave bus
);

  logic            adv;
  logic            take;
  logic            emit;
  logic            emit_rvc;
  logic [31:0]     emit_instr;
  logic [PC_W-1:0] emit_pc;

  assign adv  = !bus.out_valid || bus.out_ready;
  assign take = bus.in_valid && bus.in_ready;

`ifdef RVC_EN
  logic [0:0]      state, state_d;
  logic [15:0]     hold, hold_d;
  logic [PC_W-1:0] hold_pc, hold_pc_d;
  logic            skip_low, skip_low_d;
  logic            hold_rvc;
  logic [15:0]     lo, hi;
  logic [PC_W-1:0] hi_pc;

  assign lo       = bus.in_word[15:0];
  assign hi       = bus.in_word[31:16];
  assign hi_pc    = bus.in_pc + PC_W'(2);
  assign hold_rvc = is_rvc(hold);

  // A held compressed parcel drains on its own, so the next word must wait.
  assign bus.in_ready = !rst && adv && !bus.flush && !(state == ST_HALF && hold_rvc);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d    = state;
    hold_d     = hold;
    hold_pc_d  = hold_pc;
    skip_low_d = skip_low;
    emit       = 1'b0;
    emit_instr = '0;
    emit_pc    = bus.in_pc;
    emit_rvc   = 1'b0;

    if (bus.flush) begin
      state_d    = ST_EMPTY;
      skip_low_d = bus.redirect_pc[1];
    end else if (adv) begin
      if (state == ST_HALF && hold_rvc) begin
        emit       = 1'b1;
        emit_instr = {16'h0000, hold};
        emit_pc    = hold_pc;
        emit_rvc   = 1'b1;
        state_d    = ST_EMPTY;
      end else if (take) begin
        hold_d    = hi;
        hold_pc_d = hi_pc;
        if (state == ST_HALF) begin
          emit       = 1'b1;
          emit_instr = {lo, hold};
          emit_pc    = hold_pc;
        end else if (skip_low) begin
          skip_low_d = 1'b0;
          state_d    = ST_HALF;
        end else if (is_rvc(lo)) begin
          emit       = 1'b1;
          emit_instr = {16'h0000, lo};
          emit_rvc   = 1'b1;
          state_d    = ST_HALF;
        end else begin
          emit       = 1'b1;
          emit_instr = bus.in_word;
          hold_d     = hold;
          hold_pc_d  = hold_pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      hold     <= '0;
      hold_pc  <= '0;
      skip_low <= 1'b0;
    end else begin
      state    <= state_d;
      hold     <= hold_d;
      hold_pc  <= hold_pc_d;
      skip_low <= skip_low_d;
    end
  end
`else
  assign bus.in_ready = !rst && adv && !bus.flush;
  assign emit         = take;
  assign emit_instr   = bus.in_word;
  assign emit_pc      = bus.in_pc;
  assign emit_rvc     = 1'b0;
`endif

  // Instruction register; cleared fields whenever nothing is held.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_pc    <= RESET_PC;
      bus.out_rvc   <= 1'b0;
    end else if (bus.flush || adv) begin
      bus.out_valid <= emit;
      bus.out_instr <= emit ? emit_instr : 32'h0;
      bus.out_pc    <= emit ? emit_pc : RESET_PC;
      bus.out_rvc   <= emit && emit_rvc;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: parcel-queue reference model, directed plan cases, random traffic.
// Model and literal expectations follow RVC_EN the same way the design does.
module tb_fetch_aligner;

  localparam int          PC_W     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  typedef struct {
    logic [15:0] p;
    logic [31:0] pc;
  } parcel_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rvc;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_aligner_if #(.PC_W(PC_W)) bus ();

  fetch_aligner #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  parcel_t pq[$];
  ins_t    exp_q[$];
  ins_t    got[$];
  logic    skip      = 1'b0;
  logic    prev_rst  = 1'b0;
  logic    bp_prev   = 1'b0;
  logic [66:0] bp_snap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: parcels enter a queue, instructions are carved off its head in order.
  task automatic form_instructions();
    ins_t i;
    forever begin
      if (pq.size() == 0) break;
      if (pq[0].p[1:0] != 2'b11) begin
        i.instr = {16'h0000, pq[0].p}; i.pc = pq[0].pc; i.rvc = 1'b1;
        exp_q.push_back(i);
        void'(pq.pop_front());
      end else if (pq.size() >= 2) begin
        i.instr = {pq[1].p, pq[0].p}; i.pc = pq[0].pc; i.rvc = 1'b0;
        exp_q.push_back(i);
        void'(pq.pop_front());
        void'(pq.pop_front());
      end else begin
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    ins_t    e;
    ins_t    g;
    parcel_t pp;
    if (rst) begin
      check("reset_in_ready", bus.in_ready, 1'b0);
      pq.delete();
      exp_q.delete();
      skip    = 1'b0;
      bp_prev = 1'b0;
    end else begin
      if (prev_rst) begin
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_pc",    bus.out_pc, RESET_PC);
        check("rst_out_rvc",   bus.out_rvc, 1'b0);
      end
      if (bp_prev)
        check("stall_stable", {bus.out_valid, bus.out_instr, bus.out_pc, bus.out_rvc}, bp_snap);
      if (bus.out_valid && !bus.out_ready)
        check("stall_in_ready", bus.in_ready, 1'b0);
      if (bus.flush)
        check("flush_in_ready", bus.in_ready, 1'b0);

      if (bus.out_valid && bus.out_ready) begin
        g.instr = bus.out_instr; g.pc = bus.out_pc; g.rvc = bus.out_rvc;
        got.push_back(g);
        check("expected_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_instr", bus.out_instr, e.instr);
          check("out_pc",    bus.out_pc, e.pc);
          check("out_rvc",   bus.out_rvc, e.rvc);
        end
      end

      if (bus.flush) begin
        pq.delete();
        exp_q.delete();
`ifdef RVC_EN
        skip = bus.redirect_pc[1];
`endif
      end else if (bus.in_valid && bus.in_ready) begin
`ifdef RVC_EN
        if (!skip) begin
          pp.p = bus.in_word[15:0]; pp.pc = bus.in_pc;
          pq.push_back(pp);
        end
        skip = 1'b0;
        pp.p = bus.in_word[31:16]; pp.pc = bus.in_pc + 32'd2;
        pq.push_back(pp);
        form_instructions();
`else
        e.instr = bus.in_word; e.pc = bus.in_pc; e.rvc = 1'b0;
        exp_q.push_back(e);
`endif
      end

      bp_prev = bus.out_valid && !bus.out_ready && !bus.flush;
      bp_snap = {bus.out_valid, bus.out_instr, bus.out_pc, bus.out_rvc};
    end
    prev_rst = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    got.delete();
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] pc);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1; bus.in_word = w; bus.in_pc = pc;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    check("word_accepted", acc, 1'b1);
  endtask

  task automatic expect_got(input int idx, input logic [31:0] instr, input logic [31:0] pc,
                            input logic rvc);
    if (idx < got.size()) begin
      check($sformatf("lit%0d_instr", idx), got[idx].instr, instr);
      check($sformatf("lit%0d_pc", idx),    got[idx].pc, pc);
      check($sformatf("lit%0d_rvc", idx),   got[idx].rvc, rvc);
    end else begin
      check($sformatf("lit%0d_present", idx), got.size(), idx + 1);
    end
  endtask

  function automatic logic [15:0] rand_parcel();
    logic [15:0] p;
    p = 16'($urandom);
    if ($urandom_range(1, 0) == 1) p[1:0] = 2'b11;
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    logic        have;
    logic        acc;
    bus.flush = 1'b0; bus.redirect_pc = '0; bus.in_valid = 1'b0;
    bus.in_word = '0; bus.in_pc = '0; bus.out_ready = 1'b1;
    step();
    do_reset();

    // Two parcels from one word
    send_word(32'h0505_0505, 32'h0);
`ifdef RVC_EN
    check("two_rvc_second_ready", bus.in_ready, 1'b0);
`else
    check("two_rvc_second_ready", bus.in_ready, 1'b1);
`endif
    idle(4);
`ifdef RVC_EN
    check("two_rvc_count", got.size(), 2);
    expect_got(0, 32'h0000_0505, 32'h0, 1'b1);
    expect_got(1, 32'h0000_0505, 32'h2, 1'b1);
`else
    check("two_rvc_count", got.size(), 1);
    expect_got(0, 32'h0505_0505, 32'h0, 1'b0);
`endif

    // Instruction straddling two words
    do_reset();
    send_word(32'h0093_0505, 32'h100);
    send_word(32'h0505_0010, 32'h104);
    idle(4);
`ifdef RVC_EN
    check("straddle_count", got.size(), 3);
    expect_got(0, 32'h0000_0505, 32'h100, 1'b1);
    expect_got(1, 32'h0010_0093, 32'h102, 1'b0);
    expect_got(2, 32'h0000_0505, 32'h106, 1'b1);
`else
    check("straddle_count", got.size(), 2);
    expect_got(0, 32'h0093_0505, 32'h100, 1'b0);
    expect_got(1, 32'h0505_0010, 32'h104, 1'b0);
`endif

    // Misaligned redirect
    do_reset();
    bus.flush = 1'b1; bus.redirect_pc = 32'h202;
    step();
    bus.flush = 1'b0;
    send_word(32'h0505_ABCD, 32'h200);
    idle(4);
    check("redirect_count", got.size(), 1);
`ifdef RVC_EN
    expect_got(0, 32'h0000_0505, 32'h202, 1'b1);
`else
    expect_got(0, 32'h0505_ABCD, 32'h200, 1'b0);
`endif

    // Backpressure: output frozen, next word held off until release
    do_reset();
    bus.out_ready = 1'b0;
    send_word(32'h0010_0093, 32'h0);
    bus.in_valid = 1'b1; bus.in_word = 32'h0000_0013; bus.in_pc = 32'h4;
    repeat (3) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_out_instr", bus.out_instr, 32'h0010_0093);
      check("bp_out_pc",    bus.out_pc, 32'h0);
      check("bp_in_ready",  bus.in_ready, 1'b0);
      step();
    end
    bus.out_ready = 1'b1;
    send_word(32'h0000_0013, 32'h4);
    idle(3);
    check("bp_count", got.size(), 2);
    expect_got(0, 32'h0010_0093, 32'h0, 1'b0);
    expect_got(1, 32'h0000_0013, 32'h4, 1'b0);

    // Flush colliding with a presented word while half an instruction is held
    do_reset();
    send_word(32'h0093_0505, 32'h100);
    bus.flush = 1'b1; bus.redirect_pc = 32'h300;
    bus.in_valid = 1'b1; bus.in_word = 32'h0505_0010; bus.in_pc = 32'h104;
    @(negedge clk);
    check("collide_in_ready", bus.in_ready, 1'b0);
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("collide_out_valid", bus.out_valid, 1'b0);
    send_word(32'h0000_0013, 32'h300);
    idle(3);
    check("collide_count", got.size(), 2);
`ifdef RVC_EN
    expect_got(0, 32'h0000_0505, 32'h100, 1'b1);
`else
    expect_got(0, 32'h0093_0505, 32'h100, 1'b0);
`endif
    expect_got(1, 32'h0000_0013, 32'h300, 1'b0);

    // Reset in the middle of a straddle
    do_reset();
    send_word(32'h0093_0505, 32'h0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_out_pc",    bus.out_pc, RESET_PC);
    got.delete();
    bus.out_ready = 1'b1;
    send_word(32'h0010_0093, 32'h0);
    idle(3);
    check("midrst_count", got.size(), 1);
    expect_got(0, 32'h0010_0093, 32'h0, 1'b0);

    // Random traffic against the model
    do_reset();
    pc = 32'h0; have = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(999, 0) < 4);
      bus.flush     = ($urandom_range(99, 0) < 3);
      bus.redirect_pc = 32'($urandom_range(1023, 0)) << 1;
      bus.out_ready = ($urandom_range(3, 0) != 0);
      if (!have && $urandom_range(9, 0) < 7) begin
        have = 1'b1;
        bus.in_word = {rand_parcel(), rand_parcel()};
        bus.in_pc = pc;
      end
      bus.in_valid = have;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (rst) begin
        // pending word stays presented
      end else if (bus.flush) begin
        pc   = {bus.redirect_pc[31:2], 2'b00};
        have = 1'b0;
      end else if (acc) begin
        pc   = pc + 32'd4;
        have = 1'b0;
      end
    end

    rst = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    idle(10);
    check("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
